// File: rtl/regfile_tmp.sv
// regfile_tmp: 32-entry speculative result register file.
// Entries are allocated whole by New_entry and later receive speculative
// results through Update_entry. Two independent combinational read ports.
//
// Entry layout (73 bits):
//   [72:68] rd_reg      architectural destination register
//   [67:36] PC          instruction address
//   [35:34] Inst_type   instruction class
//   [33:2]  spec_data   speculative result
//   [1]     spec_valid  spec_data is valid
//   [0]     valid       entry is allocated
module regfile_tmp #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned WIDTH  = 73
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  Data_In,
    input  logic [ADDR_W-1:0] Waddr,
    input  logic              New_entry,
    input  logic              Update_entry,
    input  logic [ADDR_W-1:0] Rd_Addr1,
    output logic [WIDTH-1:0]  Data_out1,
    input  logic [ADDR_W-1:0] Rd_Addr2,
    output logic [WIDTH-1:0]  Data_out2
);

    // Field positions touched by a speculative update: spec_data and spec_valid.
    localparam int unsigned SPEC_HI   = 33;
    localparam int unsigned SPEC_LO   = 1;
    localparam int unsigned VALID_BIT = 0;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] wr_cur;      // current contents of the entry at Waddr
    logic [WIDTH-1:0] upd_entry;   // that entry with the speculative fields replaced
    logic             upd_hit;     // update strobe lands on an allocated entry

    // Build the merged entry for a speculative update; allocation fields are kept.
    always_comb begin
        wr_cur                     = mem[Waddr];
        upd_entry                  = wr_cur;
        upd_entry[SPEC_HI:SPEC_LO] = Data_In[SPEC_HI:SPEC_LO];
        upd_hit                    = Update_entry && wr_cur[VALID_BIT];
    end

    // Storage: synchronous clear, then full write, then guarded speculative update.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else if (New_entry) begin
            mem[Waddr] <= Data_In;
        end else if (upd_hit) begin
            mem[Waddr] <= upd_entry;
        end
    end

    // Combinational read ports; no write-to-read bypass.
    always_comb begin
        Data_out1 = mem[Rd_Addr1];
        Data_out2 = mem[Rd_Addr2];
    end

endmodule

// File: tb/tb_regfile_tmp.sv
// Self-checking bench for regfile_tmp: a directed vector table, hand-written
// corner sequences, and randomized traffic against an array reference model.
module tb_regfile_tmp;

    logic        clock;
    logic        reset;
    logic [72:0] Data_In;
    logic [4:0]  Waddr;
    logic        New_entry;
    logic        Update_entry;
    logic [4:0]  Rd_Addr1;
    logic [72:0] Data_out1;
    logic [4:0]  Rd_Addr2;
    logic [72:0] Data_out2;

    int checks = 0;
    int errors = 0;

    // Reference: one 73-bit word per entry, updated by the written rules.
    logic [72:0] ref_mem [32];

    regfile_tmp #(.DEPTH(32), .ADDR_W(5), .WIDTH(73)) dut (
        .clock        (clock),
        .reset        (reset),
        .Data_In      (Data_In),
        .Waddr        (Waddr),
        .New_entry    (New_entry),
        .Update_entry (Update_entry),
        .Rd_Addr1     (Rd_Addr1),
        .Data_out1    (Data_out1),
        .Rd_Addr2     (Rd_Addr2),
        .Data_out2    (Data_out2)
    );

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        nw;
        logic        upd;
        logic [4:0]  waddr;
        logic [72:0] din;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [72:0] exp1;
        logic [72:0] exp2;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Apply the current inputs to the model, then advance one edge; returns 1 after it.
    task automatic step();
        if (reset) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        end else if (New_entry) begin
            ref_mem[Waddr] = Data_In;
        end else if (Update_entry && ref_mem[Waddr][0]) begin
            ref_mem[Waddr][33:1] = Data_In[33:1];
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic [72:0] fill_pat(input int i);
        logic [4:0] idx;
        idx = i[4:0];
        return {idx, 32'h80000001, 2'b10, 32'h1, 1'b0, 1'b1};
    endfunction

    task automatic idle_inputs();
        reset        = 1'b0;
        New_entry    = 1'b0;
        Update_entry = 1'b0;
        Waddr        = '0;
        Data_In      = '0;
    endtask

    localparam logic [72:0] D7  = {5'd7, 32'h12345678, 2'b01, 32'hAAAAAAAA, 1'b0, 1'b1};
    localparam logic [72:0] U   = {5'd31, 32'hFFFFFFFF, 2'b11, 32'h55555555, 1'b1, 1'b0};
    localparam logic [72:0] D7U = {5'd7, 32'h12345678, 2'b01, 32'h55555555, 1'b1, 1'b1};
    localparam logic [72:0] D7B = {5'd2, 32'h0, 2'b00, 32'hDEADBEEF, 1'b1, 1'b0};
    localparam logic [72:0] E31 = {5'd31, 32'hCAFEF00D, 2'b11, 32'h0, 1'b0, 1'b1};
    localparam logic [72:0] ONES = '1;
    localparam logic [72:0] ZERO = '0;

    initial begin
        logic [72:0] w0, upd3, exp3, x9;
        logic [95:0] r96;

        // rst nw upd waddr din ra1 ra2 exp1 exp2 -- expectations read after the edge
        vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd0,  ZERO, 5'd0,  5'd31, ZERO, ZERO}; // reset clear
        vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd7,  ONES, 5'd7,  5'd0,  ZERO, ZERO}; // update on invalid dropped
        vecs[2] = '{1'b0, 1'b1, 1'b1, 5'd7,  D7,   5'd7,  5'd6,  D7,   ZERO}; // new beats update
        vecs[3] = '{1'b0, 1'b0, 1'b1, 5'd7,  U,    5'd7,  5'd8,  D7U,  ZERO}; // spec fields only
        vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd7,  D7B,  5'd7,  5'd7,  D7B,  D7B};  // overwrite, valid=0
        vecs[5] = '{1'b0, 1'b0, 1'b1, 5'd7,  U,    5'd7,  5'd0,  D7B,  ZERO}; // dropped again
        vecs[6] = '{1'b0, 1'b1, 1'b0, 5'd31, E31,  5'd31, 5'd7,  E31,  D7B};  // top index
        vecs[7] = '{1'b1, 1'b1, 1'b0, 5'd3,  ONES, 5'd31, 5'd7,  ZERO, ZERO}; // reset wins over write

        idle_inputs();
        Rd_Addr1 = '0;
        Rd_Addr2 = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        @(posedge clock);
        #1;

        // Directed vector table.
        for (int v = 0; v < 8; v++) begin
            reset        = vecs[v].rst;
            New_entry    = vecs[v].nw;
            Update_entry = vecs[v].upd;
            Waddr        = vecs[v].waddr;
            Data_In      = vecs[v].din;
            Rd_Addr1     = vecs[v].ra1;
            Rd_Addr2     = vecs[v].ra2;
            step();
            check($sformatf("vec%0d_out1", v), Data_out1, vecs[v].exp1);
            check($sformatf("vec%0d_out2", v), Data_out2, vecs[v].exp2);
        end
        idle_inputs();

        // Fill every entry, then read back each index alongside its neighbour.
        for (int i = 0; i < 32; i++) begin
            New_entry = 1'b1;
            Waddr     = 5'(i);
            Data_In   = fill_pat(i);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            Rd_Addr1 = 5'(i);
            Rd_Addr2 = 5'((i + 1) % 32);
            #1;
            check($sformatf("fill_rd1_%0d", i), Data_out1, fill_pat(i));
            check($sformatf("fill_rd2_%0d", i), Data_out2, fill_pat((i + 1) % 32));
        end

        // Wrap write to entry 0; entry 31 must be untouched.
        w0        = {5'd0, 32'hFFFFFFFF, 2'b10, 32'h1, 1'b0, 1'b1};
        New_entry = 1'b1;
        Waddr     = 5'd0;
        Data_In   = w0;
        step();
        idle_inputs();
        Rd_Addr1 = 5'd0;
        Rd_Addr2 = 5'd31;
        #1;
        check("wrap_e0", Data_out1, w0);
        check("wrap_e31", Data_out2, fill_pat(31));

        // Speculative update of an allocated entry.
        upd3         = {5'd0, 32'd0, 2'b11, 32'h1, 1'b1, 1'b1};
        exp3         = {5'd3, 32'h80000001, 2'b10, 32'h1, 1'b1, 1'b1};
        Update_entry = 1'b1;
        Waddr        = 5'd3;
        Data_In      = upd3;
        step();
        idle_inputs();
        Rd_Addr1 = 5'd3;
        Rd_Addr2 = 5'd4;
        #1;
        check("upd3", Data_out1, exp3);
        check("upd3_nbr", Data_out2, fill_pat(4));

        // Read during write: old value before the edge, new value after it.
        x9        = {5'd9, 32'h0BADF00D, 2'b01, 32'h13579BDF, 1'b1, 1'b1};
        Rd_Addr1  = 5'd9;
        Rd_Addr2  = 5'd10;
        New_entry = 1'b1;
        Waddr     = 5'd9;
        Data_In   = x9;
        #1;
        check("rdw_before", Data_out1, fill_pat(9));
        check("rdw_other_before", Data_out2, fill_pat(10));
        step();
        idle_inputs();
        check("rdw_after", Data_out1, x9);
        check("rdw_other_after", Data_out2, fill_pat(10));

        // Reset after writes clears everything, and a strobe in that cycle is lost.
        reset     = 1'b1;
        New_entry = 1'b1;
        Waddr     = 5'd12;
        Data_In   = ONES;
        step();
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            Rd_Addr1 = 5'(i);
            Rd_Addr2 = 5'(31 - i);
            #1;
            check($sformatf("clr_rd1_%0d", i), Data_out1, ZERO);
            check($sformatf("clr_rd2_%0d", i), Data_out2, ZERO);
        end

        // Randomized traffic against the reference model; reads checked before each edge.
        for (int n = 0; n < 1500; n++) begin
            r96          = {$urandom(), $urandom(), $urandom()};
            Data_In      = r96[72:0];
            if ($urandom_range(0, 3) != 0) Data_In[0] = 1'b1;
            reset        = ($urandom_range(0, 63) == 0);
            New_entry    = ($urandom_range(0, 2) == 0);
            Update_entry = ($urandom_range(0, 1) == 0);
            Waddr        = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3))
                                                       : 5'($urandom_range(0, 31));
            Rd_Addr1     = ($urandom_range(0, 3) == 0) ? Waddr : 5'($urandom_range(0, 31));
            Rd_Addr2     = 5'($urandom_range(0, 31));
            #1;
            check($sformatf("rnd%0d_out1", n), Data_out1, ref_mem[Rd_Addr1]);
            check($sformatf("rnd%0d_out2", n), Data_out2, ref_mem[Rd_Addr2]);
            step();
        end
        idle_inputs();

        // Final full sweep of the surviving state.
        for (int i = 0; i < 32; i++) begin
            Rd_Addr1 = 5'(i);
            Rd_Addr2 = 5'(i);
            #1;
            check($sformatf("final_rd1_%0d", i), Data_out1, ref_mem[i]);
            check($sformatf("final_rd2_%0d", i), Data_out2, ref_mem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
